// File: rtl/f1_pkg.sv
// f1_pkg: shared types and constants for the F1 start-light sequencer.
//   state_t   - sequencer state encoding (IDLE, FILL, HOLD, OUT)
//   lfsr_taps - Fibonacci LFSR feedback mask for a given register width
//               (bit i set => register bit i feeds the XOR)
package f1_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2,
        OUT  = 2'd3
    } state_t;

    // Maximal-length polynomials; e.g. width 7 is x^7+x^6+1 -> bits 6 and 5.
    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        logic [31:0] m;
        case (width)
            3:       m = 32'h0000_0006;
            4:       m = 32'h0000_000C;
            5:       m = 32'h0000_0014;
            6:       m = 32'h0000_0030;
            7:       m = 32'h0000_0060;
            8:       m = 32'h0000_00B8;
            9:       m = 32'h0000_0110;
            10:      m = 32'h0000_0240;
            11:      m = 32'h0000_0500;
            12:      m = 32'h0000_0E08;
            16:      m = 32'h0000_D008;
            default: m = 32'h0000_0060;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/f1_lfsr.sv
// f1_lfsr: free-running maximal-length Fibonacci LFSR, shifts every clock.
// Ports:
//   clk - system clock
//   rst - synchronous active-high reset, reloads SEED
//   q   - current LFSR value (never zero when SEED is nonzero)
module f1_lfsr
    import f1_pkg::*;
#(
    parameter int unsigned           WIDTH = 7,
    parameter logic [WIDTH-1:0]      SEED  = 7'h01
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q
);

    localparam logic [31:0] TAPS32 = lfsr_taps(WIDTH);

    logic [WIDTH-1:0] r_q;
    logic             w_fb;

    assign w_fb = ^(r_q & TAPS32[WIDTH-1:0]);
    assign q    = r_q;

    always_ff @(posedge clk) begin
        if (rst) r_q <= SEED;
        else     r_q <= {r_q[WIDTH-2:0], w_fb};
    end

endmodule

// File: rtl/f1_lights_seq.sv
// f1_lights_seq: parametrised F1 start-light sequencer.
// A trigger in IDLE starts a thermometer fill (one lamp per en tick), then all
// lamps hold lit while a delay runs, then all go dark with a lights_out pulse.
// Build option F1_INT_DELAY_EN: HOLD length comes from an internal LFSR-loaded
// down-counter clocked by en; time_out is then ignored.
// Ports:
//   clk        - system clock
//   rst        - synchronous active-high reset
//   en         - one-cycle advance tick
//   trigger    - start request (sampled in IDLE only)
//   time_out   - external delay-expired strobe (HOLD only)
//   data_out   - lamp drive, thermometer code, LSB lit first
//   cmd_seq    - high during FILL
//   cmd_delay  - one-cycle pulse on the first HOLD cycle
//   lights_out - one-cycle pulse in OUT
//   busy       - high in any state other than IDLE
module f1_lights_seq
    import f1_pkg::*;
#(
    parameter int unsigned        N_LIGHTS  = 8,
    parameter int unsigned        DELAY_W   = 7,
    parameter logic [DELAY_W-1:0] LFSR_SEED = 7'h01
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                trigger,
    input  logic                time_out,
    output logic [N_LIGHTS-1:0] data_out,
    output logic                cmd_seq,
    output logic                cmd_delay,
    output logic                lights_out,
    output logic                busy
);

    localparam int unsigned     KW     = $clog2(N_LIGHTS + 1);
    localparam logic [KW-1:0]   K_LAST = KW'(N_LIGHTS - 1);
    localparam logic [KW-1:0]   K_FULL = KW'(N_LIGHTS);

    if (N_LIGHTS < 2 || N_LIGHTS > 32 || LFSR_SEED == '0) begin : g_bad_cfg
        $error("f1_lights_seq: N_LIGHTS must be 2..32 and LFSR_SEED nonzero");
    end

    state_t        r_state, w_state_nxt;
    logic [KW-1:0] r_k, w_k_nxt;
    logic          r_first, w_first_nxt;
    logic          w_hold_done;

`ifdef F1_INT_DELAY_EN
    logic [DELAY_W-1:0] w_lfsr;
    logic [DELAY_W-1:0] r_cnt;

    f1_lfsr #(
        .WIDTH (DELAY_W),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (w_lfsr)
    );

    // HOLD ends on the en tick that takes the counter from 1 to 0.
    assign w_hold_done = en && (r_cnt == DELAY_W'(1));

    always_ff @(posedge clk) begin
        if (rst)                                        r_cnt <= '0;
        else if (r_state == FILL && w_state_nxt == HOLD) r_cnt <= w_lfsr;
        else if (r_state == HOLD && en)                 r_cnt <= r_cnt - 1'b1;
    end
`else
    assign w_hold_done = time_out;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_first <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_first <= w_first_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_first_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (trigger) begin
                    w_state_nxt = FILL;
                    w_k_nxt     = '0;
                end
            end
            FILL: begin
                if (en) begin
                    if (r_k == K_LAST) begin
                        w_state_nxt = HOLD;
                        w_k_nxt     = K_FULL;
                        w_first_nxt = 1'b1;
                    end else begin
                        w_k_nxt = r_k + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (w_hold_done) w_state_nxt = OUT;
            end
            OUT: begin
                w_state_nxt = IDLE;
                w_k_nxt     = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_k_nxt     = '0;
            end
        endcase
    end

    always_comb begin
        data_out   = '0;
        cmd_seq    = 1'b0;
        cmd_delay  = 1'b0;
        lights_out = 1'b0;
        busy       = (r_state != IDLE);
        case (r_state)
            FILL: begin
                cmd_seq = 1'b1;
                for (int unsigned i = 0; i < N_LIGHTS; i++) begin
                    data_out[i] = (i < 32'(r_k));
                end
            end
            HOLD: begin
                data_out  = '1;
                cmd_delay = r_first;
            end
            OUT: begin
                lights_out = 1'b1;
            end
            default: begin
                data_out = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_f1_lights_seq.sv
module tb_f1_lights_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       trigger = 1'b0;
    logic       time_out = 1'b0;
    logic [7:0] data_out;
    logic       cmd_seq, cmd_delay, lights_out, busy;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_fill [0:8] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F,
                                   8'h1F, 8'h3F, 8'h7F, 8'hFF};

    always #5 clk = ~clk;

    f1_lights_seq #(
        .N_LIGHTS  (8),
        .DELAY_W   (7),
        .LFSR_SEED (7'h01)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .trigger    (trigger),
        .time_out   (time_out),
        .data_out   (data_out),
        .cmd_seq    (cmd_seq),
        .cmd_delay  (cmd_delay),
        .lights_out (lights_out),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs set beforehand are applied at this edge, then cleared.
    task automatic cyc();
        @(posedge clk);
        #1;
        en = 1'b0; trigger = 1'b0; time_out = 1'b0; rst = 1'b0;
    endtask

`ifdef F1_INT_DELAY_EN
    logic [6:0] ref_lfsr;
    always @(posedge clk) begin
        if (rst) ref_lfsr <= 7'h01;
        else     ref_lfsr <= {ref_lfsr[5:0], ref_lfsr[6] ^ ref_lfsr[5]};
    end

    // Counts en ticks spent in HOLD with time_out held high; bounded.
    task automatic count_hold(output int n, output logic done);
        n = 0;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            en = 1'b1; time_out = 1'b1;
            cyc();
            n++;
            if (lights_out) done = 1'b1;
        end
    endtask

    int         n1, n2;
    logic       d1, d2;
    logic [6:0] exp1, exp2;
`endif

    initial begin
        // Reset
        rst = 1'b1; cyc();
        rst = 1'b1; cyc();
        chk("rst_data", data_out, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_seq", cmd_seq, 1'b0);
        chk("rst_delay", cmd_delay, 1'b0);
        chk("rst_lout", lights_out, 1'b0);

        // Trigger together with en: en is not counted
        trigger = 1'b1; en = 1'b1; cyc();
        chk("trig_data", data_out, 8'h00);
        chk("trig_seq", cmd_seq, 1'b1);
        chk("trig_busy", busy, 1'b1);

        // Fill, en every 4th cycle
        for (int i = 1; i <= 8; i++) begin
            repeat (3) cyc();
`ifdef F1_INT_DELAY_EN
            if (i == 8) exp1 = ref_lfsr;
`endif
            en = 1'b1; cyc();
            if (i < 8) begin
                chk("fill_data", data_out, exp_fill[i]);
                chk("fill_seq", cmd_seq, 1'b1);
            end
            if (i == 3) begin
                repeat (20) cyc();
                chk("gap_data", data_out, 8'h07);
                chk("gap_seq", cmd_seq, 1'b1);
            end
            if (i == 4) begin
                trigger = 1'b1; cyc();
                chk("fill_trig_ign", data_out, 8'h0F);
                time_out = 1'b1; cyc();
                chk("fill_to_ign", data_out, 8'h0F);
                chk("fill_to_seq", cmd_seq, 1'b1);
            end
        end
        chk("hold_data", data_out, 8'hFF);
        chk("hold_seq", cmd_seq, 1'b0);
        chk("hold_delay", cmd_delay, 1'b1);
        chk("hold_busy", busy, 1'b1);

`ifdef F1_INT_DELAY_EN
        count_hold(n1, d1);
        chk("int_done1", d1, 1'b1);
        chk("int_len1", n1, 32'(exp1));
        chk("int_out_data", data_out, 8'h00);
        cyc();
        chk("int_idle_busy", busy, 1'b0);

        trigger = 1'b1; cyc();
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) exp2 = ref_lfsr;
            en = 1'b1; cyc();
        end
        chk("int_hold2_delay", cmd_delay, 1'b1);
        count_hold(n2, d2);
        chk("int_done2", d2, 1'b1);
        chk("int_len2", n2, 32'(exp2));
        chk("int_runs_differ", (n1 != n2), 1'b1);
        cyc();
`else
        // HOLD: cmd_delay only on the first cycle; trigger and en ignored
        cyc();
        chk("hold2_delay", cmd_delay, 1'b0);
        chk("hold2_data", data_out, 8'hFF);
        trigger = 1'b1; cyc();
        chk("hold_trig_data", data_out, 8'hFF);
        chk("hold_trig_seq", cmd_seq, 1'b0);
        en = 1'b1; cyc();
        chk("hold_en_data", data_out, 8'hFF);
        repeat (6) cyc();
        time_out = 1'b1; cyc();
        chk("out_data", data_out, 8'h00);
        chk("out_lout", lights_out, 1'b1);
        chk("out_busy", busy, 1'b1);
        cyc();
        chk("idle_lout", lights_out, 1'b0);
        chk("idle_busy", busy, 1'b0);

        // time_out and en in IDLE ignored
        time_out = 1'b1; en = 1'b1; cyc();
        chk("idle_to_busy", busy, 1'b0);
        chk("idle_to_data", data_out, 8'h00);

        // Mid-operation reset at 1F
        trigger = 1'b1; cyc();
        repeat (5) begin en = 1'b1; cyc(); end
        chk("mid_pre_data", data_out, 8'h1F);
        rst = 1'b1; cyc();
        chk("mid_rst_data", data_out, 8'h00);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_seq", cmd_seq, 1'b0);
        trigger = 1'b1; cyc();
        chk("restart_data", data_out, 8'h00);
        chk("restart_seq", cmd_seq, 1'b1);
        en = 1'b1; cyc();
        chk("restart_en", data_out, 8'h01);

        // Same-cycle timeout on first HOLD cycle
        repeat (7) begin en = 1'b1; cyc(); end
        chk("sc_hold_data", data_out, 8'hFF);
        chk("sc_hold_delay", cmd_delay, 1'b1);
        time_out = 1'b1; cyc();
        chk("sc_out_lout", lights_out, 1'b1);
        chk("sc_out_data", data_out, 8'h00);

        // Trigger held across OUT->IDLE restarts on the IDLE cycle
        trigger = 1'b1; cyc();
        chk("held_idle_busy", busy, 1'b0);
        chk("held_idle_lout", lights_out, 1'b0);
        trigger = 1'b1; cyc();
        chk("held_fill_busy", busy, 1'b1);
        chk("held_fill_seq", cmd_seq, 1'b1);
        chk("held_fill_data", data_out, 8'h00);
`endif

        rst = 1'b1; cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
